burst_bus_arb: RTL and testbench
================================

Name: burst_bus_arb

Overview:
- Shares one downstream valid/ready streaming channel among N requesters at burst granularity.
- Picks a winner by least-recently-granted (LRU) matrix priority and holds the grant until that requester's last beat is accepted. Only then does the priority update.
- Includes a stall watchdog that releases the bus if the owner stops sending.
- Sits between DMA/master ports and a shared bus/memory slave port.

Parameters:
N, 4, number of requesters (2..16)
DW, 32, data width per beat
TMO, 64, idle cycles in grant before forced release (>=2)
IDW, $clog2(N), width of owner id

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  N  per-requester beat valid
req_last  in  N  per-requester last-beat flag
req_data  in  N*DW  packed beat data, requester i at [i*DW +: DW]
req_ready  out  N  per-requester ready
out_valid  out  1  downstream beat valid
out_last  out  1  downstream last beat
out_data  out  DW  downstream beat data
out_id  out  IDW  current owner index
out_ready  in  1  downstream ready
timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (rst high, async):
  - state=IDLE, owner=0, watchdog=0, timeout=0.
  - Priority matrix: row i beats col j for i<j, so requester 0 is highest.
  - All outputs 0.
- States:
  - IDLE: if any req_valid, latch the LRU winner into owner and go to GRANT the next cycle. Winner = the requester with req_valid set that no higher-priority valid requester beats. No beat transfers in IDLE.
  - GRANT:
    - out_valid = req_valid[owner], out_data = req_data[owner], out_last = req_last[owner], out_id = owner.
    - req_ready[owner] = out_ready; all other req_ready = 0.
    - A beat transfers when out_valid && out_ready.
    - Transfer with out_last: update the matrix so owner is lowest priority (row owner cleared, column owner set), then go to IDLE.
- Arbitration latency: 1 cycle from req_valid to owner registered; first beat can transfer in the 2nd cycle. There is exactly one IDLE bubble between bursts.
- Single-beat burst (valid with last together): one transfer, then release.
- out_valid is combinational from the owner's req_valid. Requesters must not drop valid without a transfer; the watchdog covers violations.
- Watchdog:
  - In GRANT, the counter increments each cycle with no transfer and clears on any transfer.
  - When the counter reaches TMO-1 without a transfer: pulse timeout for 1 cycle, update priority as for a normal release, go to IDLE.
- Matrix updates only on release (last-beat transfer or timeout), never on a mid-burst beat.
- A requester raising valid mid-burst waits; there is no preemption.
- Reset mid-burst: immediate return to IDLE/reset priority; the partial burst is dropped. Downstream must tolerate this.
- out_ready high while out_valid is low: no effect.

Decomposition:
- Package burst_arb_pkg holds:
  - state enum (IDLE, GRANT)
  - function onehot2idx
  - default TMO constant
- Sub-module lru_pick (combinational LRU matrix evaluation plus registered matrix with update strobe and winner index):
  - Inputs: req, upd, upd_idx.
  - Output: onehot gnt.
  - Same reset polarity as the parent.

Test Plan:
1. rst release, req_valid=4'b1010, 3-beat bursts each, out_ready=1:
   - owner 1 granted at cycle 2, beats at cycles 2-4.
   - IDLE at cycle 5; owner 3 granted at cycle 6.
2. All 4 requesters continuously valid, 1-beat bursts:
   - grant order 0,1,2,3,0,1… with one bubble between each.
3. Owner 2 mid-burst, out_ready low 5 cycles:
   - req_ready[2]=0, data held, no release.
   - Burst resumes and completes; the matrix is unchanged until last.
4. Owner 0 drops req_valid after beat 1, TMO=8:
   - timeout pulses 8 cycles after the last transfer.
   - Returns to IDLE; requester 1 (pending) wins next; 0 is now lowest priority.
5. rst asserted during the 2nd beat of a 4-beat burst:
   - all outputs 0 asynchronously.
   - After release, the matrix is back to reset order; requester 0 wins over 3.
6. Single-beat burst (req_valid and req_last together) on requester 3 alone:
   - one transfer with out_last=1, out_id=3.
   - Requester 3 becomes lowest priority (verify with a subsequent 3+0 contention → 0 wins).

Source files
------------

// File: rtl/burst_arb_pkg.sv
// Shared types and helpers for the burst bus arbiter.
//   state_e    : arbiter FSM states
//   DefaultTmo : default watchdog limit in idle grant cycles
//   MaxReq     : largest supported requester count
//   onehot2idx : one-hot grant vector to binary index
package burst_arb_pkg;

  typedef enum logic {StIdle, StGrant} state_e;

  localparam int unsigned DefaultTmo = 64;
  localparam int unsigned MaxReq     = 16;

  // OR-reduction of set bit positions; exact for a one-hot or all-zero input.
  function automatic logic [3:0] onehot2idx(input logic [MaxReq-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MaxReq; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lru_pick.sv
// Least-recently-granted matrix arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-requester request vector
//   upd      : strobe, move upd_idx to lowest priority
//   upd_idx  : requester being released
//   gnt      : one-hot winner among req (combinational)
// mtx_q[i][j] set means requester i beats requester j. The diagonal is kept at zero
// so it never masks a requester against itself.
module lru_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          upd,
  input  logic [IW-1:0] upd_idx,
  output logic [N-1:0]  gnt
);

  logic [N-1:0][N-1:0] mtx_q;
  logic [N-1:0]        beaten;

  // A requester loses if any other active requester beats it.
  always_comb begin
    beaten = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        beaten[i] = beaten[i] | (req[j] & mtx_q[j][i]);
      end
    end
  end

  assign gnt = req & ~beaten;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          mtx_q[i][j] <= (i < j);
        end
      end
    end else if (upd) begin
      // Row cleared, column set: released requester loses to everyone.
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (IW'(i) == upd_idx) begin
            mtx_q[i][j] <= 1'b0;
          end else if (IW'(j) == upd_idx) begin
            mtx_q[i][j] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/burst_bus_arb.sv
// Burst-granular arbiter sharing one valid/ready stream among N requesters.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester beat valid
//   req_last   : per-requester last-beat flag
//   req_data   : packed beat data, requester i at [i*DW +: DW]
//   req_ready  : per-requester ready (only the owner sees out_ready)
//   out_valid  : downstream valid, out_last / out_data / out_id follow the owner
//   out_ready  : downstream ready
//   timeout    : one-cycle pulse when the watchdog releases a stalled owner
// Grant is held for a whole burst; priority moves only on release.
module burst_bus_arb
  import burst_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = DefaultTmo,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic            out_last,
  output logic [DW-1:0]   out_data,
  output logic [IDW-1:0]  out_id,
  input  logic            out_ready,
  output logic            timeout
);

  localparam int unsigned CW = $clog2(TMO);

  state_e          state_q;
  logic [IDW-1:0]  owner_q;
  logic [CW-1:0]   cnt_q;
  logic            timeout_q;

  logic [N-1:0]    gnt;
  logic [IDW-1:0]  win_idx;
  logic            in_grant;
  logic            sel_valid;
  logic            sel_last;
  logic [DW-1:0]   sel_data;
  logic            xfer;
  logic            wd_fire;
  logic            upd;

  lru_pick #(
    .N  (N),
    .IW (IDW)
  ) u_lru_pick (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .upd     (upd),
    .upd_idx (owner_q),
    .gnt     (gnt)
  );

  assign win_idx  = IDW'(onehot2idx(MaxReq'(gnt)));
  assign in_grant = (state_q == StGrant);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == IDW'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[i*DW +: DW];
        req_ready[i] = in_grant & out_ready;
      end
    end
  end

  // Outputs are forced low outside GRANT so reset and the IDLE bubble show zeros.
  assign out_valid = in_grant & sel_valid;
  assign out_last  = in_grant & sel_last;
  assign out_data  = in_grant ? sel_data : '0;
  assign out_id    = owner_q;
  assign timeout   = timeout_q;

  assign xfer = out_valid & out_ready;
  // Counter would reach TMO-1 on this edge without a transfer.
  assign wd_fire = in_grant & ~xfer & (cnt_q == CW'(TMO - 2));
  assign upd     = (xfer & out_last) | wd_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (|req_valid) begin
            owner_q <= win_idx;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (xfer) begin
            cnt_q <= '0;
            if (out_last) state_q <= StIdle;
          end else if (wd_fire) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_bus_arb.sv
// Bench for burst_bus_arb: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a queue-based priority model.
module tb_burst_bus_arb;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic            out_last;
  logic [DW-1:0]   out_data;
  logic [IDW-1:0]  out_id;
  logic            out_ready = 1'b1;
  logic            timeout;

  burst_bus_arb #(
    .N   (N),
    .DW  (DW),
    .TMO (TMO),
    .IDW (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- requester generator ----------------
  bit            act   [N];
  int            rem   [N];
  int            dropc [N];
  bit            hold  [N];
  bit            cont  [N];
  logic [DW-1:0] dat   [N];
  bit            rand_on = 0;
  int            start_pct = 0;
  int            ordy_pct = 100;

  function automatic void start(input int i, input int len);
    act[i] = 1'b1;
    rem[i] = len;
    dat[i] = $urandom;
  endfunction

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = act[i] && dropc[i] == 0 && !hold[i];
      req_last[i]  = act[i] && rem[i] == 1;
      req_data[i*DW +: DW] = dat[i];
    end
  endfunction

  function automatic void clear_gen();
    for (int i = 0; i < N; i++) begin
      act[i] = 0; rem[i] = 0; dropc[i] = 0; hold[i] = 0; cont[i] = 0; dat[i] = '0;
    end
    rand_on = 0;
    out_ready = 1'b1;
  endfunction

  // Advance one clock; returns at posedge+1 with the new inputs applied.
  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        rem[i]--;
        dat[i] = $urandom;
        if (rem[i] == 0) act[i] = 0;
      end
      if (dropc[i] > 0) dropc[i]--;
      if (!act[i]) begin
        if (cont[i]) start(i, 1);
        else if (rand_on && $urandom_range(99) < start_pct) start(i, $urandom_range(1, 5));
      end else if (rand_on && dropc[i] == 0 && $urandom_range(63) == 0) begin
        dropc[i] = $urandom_range(2, 12);
      end
    end
    if (rand_on) out_ready = ($urandom_range(99) < ordy_pct);
    drive();
  endtask

  // Leaves the bench in cycle 1 after reset release (arbiter IDLE).
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_gen();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int            q[$];     // priority order, front is highest
  bit            m_gr = 0;
  int            m_own = 0;
  int            m_quiet = 0;
  bit            m_tmo = 0;
  logic [N-1:0]  e_rdy;
  logic          e_v;
  logic          e_l;
  logic [DW-1:0] e_d;
  int            e_id;
  logic          m_xf;
  int            pick;

  function automatic void release_owner();
    for (int k = 0; k < q.size(); k++) begin
      if (q[k] == m_own) begin
        q.delete(k);
        break;
      end
    end
    q.push_back(m_own);
    m_gr = 0;
  endfunction

  always @(negedge clk) begin
    e_rdy = '0; e_v = 1'b0; e_l = 1'b0; e_d = '0; e_id = 0;
    if (rst) begin
      q.delete();
      for (int i = 0; i < N; i++) q.push_back(i);
      m_gr = 0; m_own = 0; m_quiet = 0; m_tmo = 0;
    end else begin
      e_id = m_own;
      if (m_gr) begin
        e_v = req_valid[m_own];
        e_l = req_last[m_own];
        e_d = req_data[m_own*DW +: DW];
        e_rdy[m_own] = out_ready;
      end
    end
    chk("out_valid", 64'(out_valid), 64'(e_v));
    chk("out_last",  64'(out_last),  64'(e_l));
    chk("out_data",  64'(out_data),  64'(e_d));
    chk("out_id",    64'(out_id),    64'(e_id));
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("timeout",   64'(timeout),   64'(rst ? 1'b0 : m_tmo));
    if (!rst) begin
      m_tmo = 0;
      if (!m_gr) begin
        if (req_valid != '0) begin
          pick = 0;
          for (int k = q.size() - 1; k >= 0; k--) if (req_valid[q[k]]) pick = q[k];
          m_own = pick; m_gr = 1; m_quiet = 0;
        end
      end else begin
        m_xf = req_valid[m_own] && out_ready;
        if (m_xf && req_last[m_own]) begin
          release_owner();
        end else if (m_xf) begin
          m_quiet = 0;
        end else begin
          m_quiet++;
          if (m_quiet == TMO - 1) begin
            release_owner();
            m_tmo = 1;
          end
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  initial begin
    clear_gen();
    drive();

    // 1: requesters 1 and 3, three beats each.
    do_reset();
    start(1, 3); start(3, 3); drive();
    #2 chk("t1 c1 idle", 64'(out_valid), 64'd0);
    step(); #2;
    chk("t1 c2 id", 64'(out_id), 64'd1);
    chk("t1 c2 valid", 64'(out_valid), 64'd1);
    chk("t1 c2 ready", 64'(req_ready), 64'b0010);
    step(); step(); #2;
    chk("t1 c4 last", 64'(out_last), 64'd1);
    step(); #2;
    chk("t1 c5 bubble", 64'(out_valid), 64'd0);
    step(); #2;
    chk("t1 c6 id", 64'(out_id), 64'd3);
    chk("t1 c6 valid", 64'(out_valid), 64'd1);

    // 2: all continuously valid, single-beat bursts rotate 0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++) begin cont[i] = 1; start(i, 1); end
    drive();
    for (int c = 0; c < 8; c++) begin
      step(); #2;
      chk("t2 grant id", 64'(out_id), 64'(c % 4));
      chk("t2 grant valid", 64'(out_valid), 64'd1);
      step(); #2;
      chk("t2 bubble", 64'(out_valid), 64'd0);
    end

    // 3: owner 2 back-pressured for five cycles, requester 0 waits.
    do_reset();
    start(2, 4); drive();
    step();
    step();
    out_ready = 1'b0; start(0, 2); drive();
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t3 stall ready", 64'(req_ready), 64'd0);
      chk("t3 stall data", 64'(out_data), 64'(dat[2]));
      chk("t3 stall id", 64'(out_id), 64'd2);
      step();
    end
    out_ready = 1'b1; drive();
    step(); step(); #2;
    chk("t3 last id", 64'(out_id), 64'd2);
    chk("t3 last flag", 64'(out_last), 64'd1);
    step(); #2;
    chk("t3 bubble", 64'(out_valid), 64'd0);
    step(); #2;
    chk("t3 next id", 64'(out_id), 64'd0);

    // 4: owner 0 stops after one beat; watchdog releases it.
    do_reset();
    start(0, 4); start(1, 2); drive();
    step();
    step();
    hold[0] = 1; drive();
    repeat (6) step();
    #2;
    chk("t4 c9 no timeout", 64'(timeout), 64'd0);
    chk("t4 c9 id", 64'(out_id), 64'd0);
    step(); #2;
    chk("t4 c10 timeout", 64'(timeout), 64'd1);
    chk("t4 c10 idle", 64'(out_valid), 64'd0);
    hold[0] = 0; drive();
    step(); #2;
    chk("t4 c11 pulse end", 64'(timeout), 64'd0);
    chk("t4 c11 id", 64'(out_id), 64'd1);

    // 5: asynchronous reset during the second beat.
    do_reset();
    start(3, 4); drive();
    step();
    step();
    start(0, 1); drive();
    #1 rst = 1'b1;
    #1;
    chk("t5 rst valid", 64'(out_valid), 64'd0);
    chk("t5 rst ready", 64'(req_ready), 64'd0);
    chk("t5 rst id", 64'(out_id), 64'd0);
    chk("t5 rst data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    clear_gen();
    rst = 1'b0;
    start(0, 2); start(3, 2); drive();
    step(); #2;
    chk("t5 after id", 64'(out_id), 64'd0);

    // 6: single-beat burst on requester 3 alone.
    do_reset();
    start(3, 1); drive();
    step(); #2;
    chk("t6 valid", 64'(out_valid), 64'd1);
    chk("t6 last", 64'(out_last), 64'd1);
    chk("t6 id", 64'(out_id), 64'd3);
    step();
    start(0, 1); start(3, 1); drive();
    step(); #2;
    chk("t6 contention id", 64'(out_id), 64'd0);

    // Random traffic with protocol violations and back-pressure.
    do_reset();
    rand_on = 1; start_pct = 25; ordy_pct = 75;
    repeat (4000) step();
    ordy_pct = 40; start_pct = 60;
    repeat (2000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
